// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
package ps2_host_tx_pkg;

  localparam int unsigned DATA_W             = 8;
  localparam int unsigned EDGE_W             = 4;
  localparam int unsigned FRAME_EDGES        = 11;
  localparam int unsigned DEF_INHIBIT_CYCLES = 12000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 2000000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INHIBIT = 3'd1,
    SEND    = 3'd2,
    ACK     = 3'd3,
    DONE    = 3'd4
  } state_t;

  function automatic logic odd_parity(input logic [DATA_W-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_sync.sv
// Two-flop synchronizer for an idle-high PS/2 line plus falling-edge detect.
module ps2_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync,
  output logic fall_c
);

  logic meta;
  logic sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b1;
      sync   <= 1'b1;
      sync_d <= 1'b1;
    end else begin
      meta   <= async_in;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign fall_c = sync_d & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-edge frame, ACK check.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              ps2_clk_in,
  input  logic              ps2_data_in,
  output logic              ps2_clk_oe,
  output logic              ps2_data_oe,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  logic sync_clk_unused;
  logic clk_fall;
  logic sync_data;
  logic data_fall_unused;

  ps2_sync u_clk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_in(ps2_clk_in),
    .sync   (sync_clk_unused),
    .fall_c (clk_fall)
  );

  ps2_sync u_data_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_in(ps2_data_in),
    .sync   (sync_data),
    .fall_c (data_fall_unused)
  );

  state_t                state_q, state_d;
  logic [INH_W-1:0]      inh_q, inh_d;
  logic [EDGE_W-1:0]     edge_q, edge_d;
  logic [TO_W-1:0]       to_q, to_d;
  logic [DATA_W:0]       frame_q, frame_d;
  logic [FRAME_EDGES-2:0] bits_d;
  logic                  err_d;
  logic                  tx_ready_d, clk_oe_d, data_oe_d, busy_d, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      inh_q       <= '0;
      edge_q      <= '0;
      to_q        <= '0;
      frame_q     <= '0;
      err         <= 1'b0;
      tx_ready    <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      inh_q       <= inh_d;
      edge_q      <= edge_d;
      to_q        <= to_d;
      frame_q     <= frame_d;
      err         <= err_d;
      tx_ready    <= tx_ready_d;
      ps2_clk_oe  <= clk_oe_d;
      ps2_data_oe <= data_oe_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  // Next state; outputs are decoded from the next state so they register in step with it.
  always_comb begin
    state_d    = state_q;
    inh_d      = inh_q;
    edge_d     = edge_q;
    to_d       = to_q;
    frame_d    = frame_q;
    err_d      = err;
    bits_d     = '0;
    tx_ready_d = 1'b0;
    clk_oe_d   = 1'b0;
    data_oe_d  = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          frame_d = {odd_parity(tx_data), tx_data};
          inh_d   = '0;
          edge_d  = '0;
          to_d    = '0;
          err_d   = 1'b0;
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_q == INH_W'(INHIBIT_CYCLES - 1)) state_d = SEND;
        else                                      inh_d   = inh_q + INH_W'(1);
      end
      SEND, ACK: begin
        // A device edge wins over a timeout landing in the same cycle.
        if (clk_fall) begin
          to_d   = '0;
          edge_d = edge_q + EDGE_W'(1);
          if (state_q == ACK) begin
            err_d   = sync_data;
            state_d = DONE;
          end else if (edge_q == EDGE_W'(FRAME_EDGES - 2)) begin
            state_d = ACK;
          end
        end else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bit driven after edge k is frame bit k; bit 0 is the start bit.
    bits_d     = {frame_d, 1'b0};
    tx_ready_d = (state_d == IDLE);
    busy_d     = (state_d == INHIBIT) || (state_d == SEND) || (state_d == ACK);
    done_d     = (state_d == DONE);
    clk_oe_d   = (state_d == INHIBIT);
    if (state_d == INHIBIT)
      data_oe_d = (inh_d == INH_W'(INHIBIT_CYCLES - 1));
    else if (state_d == SEND && edge_d < EDGE_W'(FRAME_EDGES - 1))
      data_oe_d = ~bits_d[edge_d];
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The block SHALL have parameter INHIBIT_CYCLES, default 12000, clock-low request hold in clk cycles (120 us at 100 MHz).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 2000000, maximum clk cycles between device clock falling edges (20 ms at 100 MHz).
REQ-003 clk  input  1  system clock; the only clock; all state on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 tx_data  input  8  command byte to send to the device.
REQ-006 tx_valid  input  1  request to send tx_data.
REQ-007 tx_ready  output  1  high when idle and able to accept a byte.
REQ-008 ps2_clk_in  input  1  sensed PS2_CLK line, asynchronous.
REQ-009 ps2_data_in  input  1  sensed PS2_DATA line, asynchronous.
REQ-010 ps2_clk_oe  output  1  1 = pull PS2_CLK low; 0 = release (open drain).
REQ-011 ps2_data_oe  output  1  1 = pull PS2_DATA low; 0 = release.
REQ-012 busy  output  1  high from accept until done; lets the receiver ignore host-driven frames.
REQ-013 done  output  1  one-cycle pulse when a transfer ends.
REQ-014 err  output  1  valid with done: 1 = no ACK or timeout, 0 = ACK received.

Function
REQ-015 ps2_clk_in and ps2_data_in SHALL pass through 2-flop synchronizers; a falling edge is sync_clk 1->0 across consecutive cycles.
REQ-016 States SHALL be IDLE, INHIBIT, SEND, ACK, DONE.
REQ-017 IDLE: tx_ready=1, both oe=0; a byte is accepted when tx_valid&&tx_ready, latching tx_data and odd parity (~^tx_data), clearing counters, entering INHIBIT next cycle.
REQ-018 tx_valid while not in IDLE SHALL be ignored; no queuing.
REQ-019 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles; ps2_data_oe=1 during the final cycle only; then SEND.
REQ-020 SEND: ps2_clk_oe=0; start bit held (data_oe=1) until the first falling edge; at falling edge k=1..8 drive data bit k-1 (LSB first), k=9 parity, k=10 stop (data_oe=0); data_oe = ~bit.
REQ-021 After falling edge 10, ACK: data_oe=0; at falling edge 11 sample sync_data: 0 sets err=0, 1 sets err=1; then DONE.
REQ-022 DONE: done=1 for one cycle with err valid, busy=0 on return; IDLE next cycle.
REQ-023 The 4-bit edge counter SHALL never exceed 11.
REQ-024 In SEND/ACK a timeout counter SHALL clear on each falling edge; reaching TIMEOUT_CYCLES releases both lines, sets err=1, enters DONE.
REQ-025 Simultaneous timeout and falling edge SHALL favour the edge.
REQ-026 busy=1 in INHIBIT, SEND, ACK; 0 in IDLE and DONE.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_ready=0 while asserted, busy=0, done=0, err=0, counters and synchronizers cleared (sync to 1, idle-high bus).
REQ-028 Reset mid-transfer SHALL abandon the frame without a done pulse; tx_ready=1 first cycle after deassertion.

Structure
REQ-029 A shared package SHALL hold the state encoding, FRAME_EDGES=11, and default INHIBIT/TIMEOUT constants.
REQ-030 One sub-module ps2_sync SHALL implement the 2-flop synchronizer plus falling-edge detect, instantiated for clock (with edge) and data.

Verification
REQ-031 Send 0xED, device model clocks at 12.5 kHz and ACKs -> clk_oe high 12000 cycles, data bits 1,0,1,1,0,1,1,1 LSB first, parity 1, stop released, done with err=0.
REQ-032 Send 0x00 -> parity bit 1, data_oe=1 for bits 0..7, done err=0.
REQ-033 Device omits ACK (data high at edge 11) -> done with err=1.
REQ-034 Device stops clocking after edge 4 -> after TIMEOUT_CYCLES both oe=0, done err=1, tx_ready=1 next+1 cycle.
REQ-035 rst_n pulsed low during edge 6 -> oe released immediately, no done, new 0xFF transfer completes err=0.
REQ-036 tx_valid held high across a transfer with changing tx_data -> only byte at acceptance sent; next byte accepted only after DONE.
